// File: rtl/fme_win_loader.sv
// fme_win_loader: writer side of the 16x16 integer-pixel window read by the
// half-pel interpolator. Raster-ordered reference pixels arrive on a
// valid/ready stream and fill two ping-pong banks. A full bank is presented
// with its centre index, the interpolator is restarted with an active-low
// pulse, and the bank is released once the interpolator reports done.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready stream handshake; s_data pixel, s_last window end marker,
//                   s_ctr centre index (sampled on beat 0 of a window)
//   lut_out         presented bank, pixel k at [PIX_W*k +: PIX_W]
//   int_ind_pix     centre index of the presented bank
//   ip_rst_n        active-low interpolator restart
//   ip_done         interpolator done (level)
//   win_valid       a bank is being presented
//   win_cnt         windows released (wrapping)
//   err_frame       sticky: s_last disagreed with the beat count
//   err_timeout     sticky: R_WAIT watchdog fired
//
// Build option: define FME_WIN_TIMEOUT_EN to enable the R_WAIT watchdog
// (TIMEOUT_CYC cycles). Without it R_WAIT waits for ip_done indefinitely.

module fme_win_loader #(
  parameter int PIX_W       = 8,
  parameter int WIN_PIX     = 256,
  parameter int RST_CYC     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [PIX_W-1:0]         s_data,
  input  logic                     s_last,
  input  logic [7:0]               s_ctr,
  output logic [WIN_PIX*PIX_W-1:0] lut_out,
  output logic [7:0]               int_ind_pix,
  output logic                     ip_rst_n,
  input  logic                     ip_done,
  output logic                     win_valid,
  output logic [15:0]              win_cnt,
  output logic                     err_frame,
  output logic                     err_timeout
);

  localparam int IDX_W = $clog2(WIN_PIX);
  localparam int RC_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [1:0] {
    R_IDLE,
    R_RST,
    R_WAIT,
    R_REL
  } rd_state_t;

  rd_state_t        state;
  logic [1:0]       full;
  logic             wr_sel;
  logic             rd_sel;
  logic [IDX_W-1:0] wr_cnt;
  logic [RC_W-1:0]  rst_cnt;
  logic             wait_first;
  logic             ip_rst_n_q;

  logic [PIX_W-1:0] bank_mem [2][WIN_PIX];
  logic [7:0]       ctr [2];

  logic beat_acc;
  logic beat_end;
  logic full_set;
  logic full_clr;

  assign s_ready  = !rst && !full[wr_sel];
  assign beat_acc = s_valid && s_ready;
  assign beat_end = (wr_cnt == IDX_W'(WIN_PIX - 1));
  assign full_set = beat_acc && beat_end;
  assign full_clr = (state == R_REL);

  // The register idles high so the restart line is released the cycle rst
  // drops; the gate holds it low throughout reset itself.
  assign ip_rst_n = ip_rst_n_q && !rst;

  // Pixel storage carries no reset; contents are don't-care until a bank
  // has been completely written.
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      bank_mem[wr_sel][wr_cnt] <= s_data;
      if (wr_cnt == '0) begin
        ctr[wr_sel] <= s_ctr;
      end
    end
  end

  always_comb begin
    lut_out = '0;
    for (int unsigned k = 0; k < WIN_PIX; k++) begin
      lut_out[PIX_W*k +: PIX_W] = bank_mem[rd_sel][k[IDX_W-1:0]];
    end
  end

`ifdef FME_WIN_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= R_IDLE;
      full        <= '0;
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      wr_cnt      <= '0;
      rst_cnt     <= '0;
      wait_first  <= 1'b0;
      ip_rst_n_q  <= 1'b1;
      win_valid   <= 1'b0;
      int_ind_pix <= '0;
      win_cnt     <= '0;
      err_frame   <= 1'b0;
`ifdef FME_WIN_TIMEOUT_EN
      to_cnt      <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      // Write side: the beat count alone decides where a window ends.
      if (beat_acc) begin
        wr_cnt <= beat_end ? '0 : wr_cnt + 1'b1;
        if (beat_end) begin
          wr_sel <= !wr_sel;
        end
        if (s_last != beat_end) begin
          err_frame <= 1'b1;
        end
      end

      // A set and a clear in the same cycle always hit different banks.
      if (full_set) begin
        full[wr_sel] <= 1'b1;
      end
      if (full_clr) begin
        full[rd_sel] <= 1'b0;
      end

      case (state)
        R_IDLE: begin
          ip_rst_n_q <= 1'b1;
          win_valid  <= 1'b0;
          if (full[rd_sel]) begin
            state       <= R_RST;
            rst_cnt     <= RC_W'(RST_CYC - 1);
            ip_rst_n_q  <= 1'b0;
            win_valid   <= 1'b1;
            int_ind_pix <= ctr[rd_sel];
          end
        end

        R_RST: begin
          if (rst_cnt == '0) begin
            state      <= R_WAIT;
            ip_rst_n_q <= 1'b1;
            wait_first <= 1'b1;
`ifdef FME_WIN_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end

        R_WAIT: begin
          // Done is stale on the first cycle after the restart pulse.
          wait_first <= 1'b0;
          if (!wait_first && ip_done) begin
            state     <= R_REL;
            win_valid <= 1'b0;
          end
`ifdef FME_WIN_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            state       <= R_REL;
            win_valid   <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        R_REL: begin
          rd_sel  <= !rd_sel;
          win_cnt <= win_cnt + 16'd1;
          state   <= R_IDLE;
        end

        default: state <= R_IDLE;
      endcase
    end
  end

`ifndef FME_WIN_TIMEOUT_EN
  // Watchdog compiled out; TIMEOUT_CYC stays on the interface unchanged.
  assign err_timeout = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_fme_win_loader.sv
module tb_fme_win_loader;

  localparam int PIX_W       = 8;
  localparam int WIN_PIX     = 256;
  localparam int RST_CYC     = 2;
  localparam int TIMEOUT_CYC = 64;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic [PIX_W-1:0]         s_data = '0;
  logic                     s_last = 1'b0;
  logic [7:0]               s_ctr = '0;
  logic [WIN_PIX*PIX_W-1:0] lut_out;
  logic [7:0]               int_ind_pix;
  logic                     ip_rst_n;
  logic                     ip_done = 1'b0;
  logic                     win_valid;
  logic [15:0]              win_cnt;
  logic                     err_frame;
  logic                     err_timeout;

  fme_win_loader #(
    .PIX_W      (PIX_W),
    .WIN_PIX    (WIN_PIX),
    .RST_CYC    (RST_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ctr      (s_ctr),
    .lut_out    (lut_out),
    .int_ind_pix(int_ind_pix),
    .ip_rst_n   (ip_rst_n),
    .ip_done    (ip_done),
    .win_valid  (win_valid),
    .win_cnt    (win_cnt),
    .err_frame  (err_frame),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: completed windows queue up in stream order and must be
  // presented in that same order; the loader holds at most two of them.
  typedef struct packed {
    logic [7:0]               ctr;
    logic [WIN_PIX*PIX_W-1:0] pix;
  } win_t;

  win_t        exp_q [$];
  win_t        cur;
  int unsigned cur_cnt     = 0;
  int unsigned exp_win_cnt = 0;
  logic        wv_prev     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_push(input logic [7:0] d, input logic [7:0] c);
    if (cur_cnt == 0) cur.ctr = c;
    cur.pix[8*cur_cnt +: 8] = d;
    cur_cnt++;
    if (cur_cnt == WIN_PIX) begin
      exp_q.push_back(cur);
      cur_cnt = 0;
    end
  endfunction

  // Each newly presented bank must match the oldest outstanding window.
  always @(negedge clk) begin : presentation_check
    win_t w;
    int   bad;
    if (win_valid === 1'b1 && wv_prev !== 1'b1) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL present_expected: observed no pending window required one");
      end
      if (exp_q.size() != 0) begin
        w   = exp_q.pop_front();
        bad = -1;
        for (int k = 0; k < WIN_PIX; k++)
          if (bad < 0 && lut_out[8*k +: 8] !== w.pix[8*k +: 8]) bad = k;
        chk("present_ctr", {24'd0, int_ind_pix}, {24'd0, w.ctr});
        n_assert++;
        assert (bad < 0) else begin
          n_fail++;
          $error("FAIL present_lut: pixel %0d observed %0h expected %0h",
                 bad, lut_out[8*bad +: 8], w.pix[8*bad +: 8]);
        end
      end
    end
    wv_prev = win_valid;
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic beat(input logic [7:0] d, input logic [7:0] c, input logic l, output logic acc);
    s_valid = 1'b1;
    s_data  = d;
    s_ctr   = c;
    s_last  = l;
    #1 acc = s_ready;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (acc) model_push(d, c);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] c, input logic l);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 400 && !acc; i++) beat(d, c, l, acc);
    if (!acc) chk("send_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic send_window(input logic [7:0] c, input int last_at);
    for (int i = 0; i < WIN_PIX; i++)
      send(8'($urandom_range(0, 255)), c, i == last_at);
  endtask

  task automatic wait_rwait(input string tag);
    int i;
    i = 0;
    while (!(win_valid === 1'b1 && ip_rst_n === 1'b1) && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (i >= 200) chk(tag, {31'd0, win_valid & ip_rst_n}, 32'd1);
  endtask

  task automatic release_win(input string tag);
    int i;
    wait_rwait({tag, "_wait"});
    ip_done = 1'b1;
    i = 0;
    while (win_valid === 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    ip_done = 1'b0;
    chk({tag, "_wv_low"}, {31'd0, win_valid}, 32'd0);
    exp_win_cnt++;
    @(negedge clk);
    chk({tag, "_win_cnt"}, {16'd0, win_cnt}, exp_win_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    ip_done = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
    chk("rst_s_ready",     {31'd0, s_ready},     32'd0);
    chk("rst_win_valid",   {31'd0, win_valid},   32'd0);
    chk("rst_ip_rst_n",    {31'd0, ip_rst_n},    32'd0);
    chk("rst_int_ind_pix", {24'd0, int_ind_pix}, 32'd0);
    chk("rst_win_cnt",     {16'd0, win_cnt},     32'd0);
    chk("rst_err_frame",   {31'd0, err_frame},   32'd0);
    chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cur_cnt     = 0;
    exp_win_cnt = 0;
    #1;
    chk("post_rst_s_ready",  {31'd0, s_ready},  32'd1);
    chk("post_rst_ip_rst_n", {31'd0, ip_rst_n}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed no finish required finish by 1ms");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic       acc;
    logic [7:0] c0, c1, c2, d512;
    int         n, i;

    // Single window: data = index, centre 0x88, done 26 cycles after restart.
    do_reset();
    for (int k = 0; k < WIN_PIX; k++) send(8'(k), 8'h88, k == WIN_PIX - 1);
    chk("t1_idle_wv",    {31'd0, win_valid}, 32'd0);
    chk("t1_idle_rstn",  {31'd0, ip_rst_n},  32'd1);
    @(negedge clk);
    chk("t1_rst0_rstn",  {31'd0, ip_rst_n},  32'd0);
    chk("t1_rst0_wv",    {31'd0, win_valid}, 32'd1);
    chk("t1_ctr",        {24'd0, int_ind_pix}, 32'h88);
    chk("t1_pix17",      {24'd0, lut_out[17*8 +: 8]}, 32'h11);
    @(negedge clk);
    chk("t1_rst1_rstn",  {31'd0, ip_rst_n},  32'd0);
    @(negedge clk);
    chk("t1_wait_rstn",  {31'd0, ip_rst_n},  32'd1);
    chk("t1_wait_wv",    {31'd0, win_valid}, 32'd1);
    repeat (26) @(negedge clk);
    chk("t1_still_wv",   {31'd0, win_valid}, 32'd1);
    ip_done = 1'b1;
    i = 0;
    while (win_valid === 1'b1 && i < 20) begin @(negedge clk); i++; end
    ip_done = 1'b0;
    chk("t1_rel_wv",     {31'd0, win_valid}, 32'd0);
    exp_win_cnt++;
    @(negedge clk);
    chk("t1_win_cnt",    {16'd0, win_cnt},   exp_win_cnt);
    chk("t1_end_wv",     {31'd0, win_valid}, 32'd0);

    // Back-to-back: two banks fill, third window stalls until a release.
    do_reset();
    c0 = 8'($urandom_range(0, 255));
    c1 = 8'($urandom_range(0, 255));
    c2 = 8'($urandom_range(0, 255));
    send_window(c0, WIN_PIX - 1);
    send_window(c1, WIN_PIX - 1);
    chk("b2b_stall", {31'd0, s_ready}, 32'd0);
    d512    = 8'($urandom_range(0, 255));
    s_valid = 1'b1;
    s_data  = d512;
    s_ctr   = c2;
    repeat (4) begin
      @(negedge clk);
      chk("b2b_hold", {31'd0, s_ready}, 32'd0);
    end
    ip_done = 1'b1;
    @(negedge clk);
    chk("b2b_rel_ready", {31'd0, s_ready},   32'd0);
    chk("b2b_rel_wv",    {31'd0, win_valid}, 32'd0);
    ip_done = 1'b0;
    exp_win_cnt++;
    @(negedge clk);
    chk("b2b_rel_cnt", {16'd0, win_cnt}, exp_win_cnt);
    beat(d512, c2, 1'b0, acc);
    chk("b2b_ready_after_rel", {31'd0, acc}, 32'd1);
    for (int k = 1; k < WIN_PIX; k++)
      send(8'($urandom_range(0, 255)), c2, k == WIN_PIX - 1);
    release_win("b2b_w1");
    release_win("b2b_w2");

    // Framing: early s_last, none on the final beat.
    do_reset();
    ip_done = 1'b1;
    c0 = 8'($urandom_range(0, 255));
    for (int k = 0; k < WIN_PIX; k++) begin
      send(8'($urandom_range(0, 255)), c0, k == 100);
      if (k == 99)  chk("frame_err_clear", {31'd0, err_frame}, 32'd0);
      if (k == 100) chk("frame_err_set",   {31'd0, err_frame}, 32'd1);
    end
    i = 0;
    while (win_valid !== 1'b1 && i < 10) begin @(negedge clk); i++; end
    n = 0;
    while (win_valid === 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("frame_present_cycles", n, RST_CYC + 2);
    ip_done = 1'b0;
    exp_win_cnt++;
    @(negedge clk);
    chk("frame_win_cnt",   {16'd0, win_cnt},   exp_win_cnt);
    chk("frame_err_stick", {31'd0, err_frame}, 32'd1);

    // Reset mid-window discards the partial window.
    do_reset();
    for (int k = 0; k < 130; k++) send(8'($urandom_range(0, 255)), 8'h5A, 1'b0);
    do_reset();
    c0 = 8'($urandom_range(0, 255));
    send_window(c0, WIN_PIX - 1);
    release_win("midrst");

    // Bank 1 completes on the same edge that releases bank 0.
    do_reset();
    send_window(8'($urandom_range(0, 255)), WIN_PIX - 1);
    c1 = 8'($urandom_range(0, 255));
    for (int k = 0; k < WIN_PIX - 1; k++) send(8'($urandom_range(0, 255)), c1, 1'b0);
    wait_rwait("simul_wait");
    @(negedge clk);
    ip_done = 1'b1;
    @(negedge clk);
    chk("simul_in_rel", {31'd0, win_valid}, 32'd0);
    ip_done = 1'b0;
    beat(8'($urandom_range(0, 255)), c1, 1'b1, acc);
    exp_win_cnt++;
    chk("simul_last_acc", {31'd0, acc},       32'd1);
    chk("simul_ready",    {31'd0, s_ready},   32'd1);
    chk("simul_win_cnt",  {16'd0, win_cnt},   exp_win_cnt);
    chk("simul_idle_wv",  {31'd0, win_valid}, 32'd0);
    @(negedge clk);
    chk("simul_present",  {31'd0, win_valid}, 32'd1);
    send_window(8'($urandom_range(0, 255)), WIN_PIX - 1);
    release_win("simul_b");
    release_win("simul_c");

`ifdef FME_WIN_TIMEOUT_EN
    // Watchdog: done never arrives.
    do_reset();
    send_window(8'($urandom_range(0, 255)), WIN_PIX - 1);
    wait_rwait("to_wait");
    n = 0;
    while (win_valid === 1'b1 && ip_rst_n === 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("to_wait_cycles", n, TIMEOUT_CYC);
    chk("to_err",         {31'd0, err_timeout}, 32'd1);
    exp_win_cnt++;
    @(negedge clk);
    chk("to_win_cnt",     {16'd0, win_cnt}, exp_win_cnt);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fme_win_loader.md
Name: fme_win_loader

Overview:
- Writer side of the 16x16 integer-pixel window (the 256x8 "lut") that the half-pel interpolator reads.
- Accepts raster-ordered reference pixels over a valid/ready stream into ping-pong banks.
- Presents a full bank plus its centre index to the interpolator, restarts it with an active-low reset pulse, and releases the bank when the interpolator's done is seen.
- Sits between the reference-fetch DMA and the FME half-pel stage.

Parameters:
- PIX_W, 8, pixel width in bits
- WIN_PIX, 256, pixels per window (16x16); index width is 8
- RST_CYC, 2, cycles ip_rst_n is held low per window start
- TIMEOUT_CYC, 64, watchdog limit in cycles; used only with FME_WIN_TIMEOUT_EN

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  stream beat valid
- s_ready  out  1  loader can accept a beat
- s_data  in  PIX_W  pixel, raster order, index 0 first
- s_last  in  1  marks the final beat of a window
- s_ctr  in  8  window centre index; sampled on beat 0 only
- lut_out  out  WIN_PIX*PIX_W  presented bank, flattened; pixel k at [PIX_W*k+PIX_W-1 : PIX_W*k]
- int_ind_pix  out  8  centre index of the presented bank
- ip_rst_n  out  1  active-low restart to the interpolator
- ip_done  in  1  interpolator done, level
- win_valid  out  1  a bank is being presented
- win_cnt  out  16  windows released, wraps at 65535 to 0
- err_frame  out  1  sticky: s_last was inconsistent with the beat count
- err_timeout  out  1  sticky: watchdog fired

Behaviour:
- Reset state (rst high, asynchronous):
  - Bank-full flags = 0, wr_sel = 0, rd_sel = 0, wr_cnt = 0.
  - Read FSM = R_IDLE.
  - Outputs: s_ready 0, win_valid 0, ip_rst_n 0, int_ind_pix 0, win_cnt 0, err_frame 0, err_timeout 0.
  - lut_out is not reset; it is don't-care while win_valid = 0.
- Reset deasserted mid-window: the partial window and both banks are discarded. The first beat after reset is index 0 of bank 0.
- Write side:
  - s_ready = !full[wr_sel], registered-free, and 0 during rst.
  - A beat is accepted when s_valid && s_ready. It writes bank[wr_sel][wr_cnt] and increments wr_cnt.
  - On the beat with wr_cnt == 0, s_ctr is captured into ctr[wr_sel].
  - On the beat with wr_cnt == 255: full[wr_sel] <= 1, wr_sel toggles, wr_cnt wraps to 0.
  - s_ready drops in the next cycle if the other bank is full.
  - The beat count is authoritative. err_frame is set if s_last = 1 on a beat with wr_cnt != 255, or s_last = 0 on the beat with wr_cnt = 255. The window still completes on count.
- Read FSM:
  - R_IDLE: win_valid 0, ip_rst_n 1. If full[rd_sel], go to R_RST and load the RST_CYC counter.
  - R_RST: win_valid 1. lut_out = bank[rd_sel], int_ind_pix = ctr[rd_sel]. ip_rst_n 0 for exactly RST_CYC cycles, then go to R_WAIT.
  - R_WAIT: ip_rst_n 1, win_valid 1. ip_done is ignored in the first cycle of R_WAIT, because the interpolator's done is still clearing. When ip_done = 1 after that, go to R_REL.
  - R_REL: full[rd_sel] <= 0, rd_sel toggles, win_cnt increments, win_valid 0, then go to R_IDLE.
- Latency: the last beat is accepted at edge t. full is visible at t+1, R_RST is entered at t+2, and ip_rst_n is low during cycles t+2 .. t+1+RST_CYC.
- Bank ownership:
  - Each full flag is set only by the write side on a bank with flag 0. It is cleared only by R_REL on a bank with flag 1.
  - A set and a clear in the same cycle always target different banks, and both take effect.
  - A bank released in R_REL shows s_ready = 1 in the next cycle if wr_sel points to it.
- Outside R_RST, ip_rst_n is 1 whenever rst = 0.

Optional Feature:
- Macro: FME_WIN_TIMEOUT_EN.
- When defined: a counter runs in R_WAIT. If ip_done is not seen within TIMEOUT_CYC cycles of entering R_WAIT, the FSM goes to R_REL (the bank is released and win_cnt increments) and err_timeout is set sticky.
- When undefined: R_WAIT waits indefinitely, err_timeout is tied to 0, and no counter logic is present.

Test Plan:
- Single window: stream data = index mod 256 with s_ctr = 0x88, model ip_done high 26 cycles after ip_rst_n rises -> lut_out pixel 17 = 0x11; int_ind_pix = 0x88; ip_rst_n low for 2 cycles starting 2 cycles after the last beat; win_cnt = 1; win_valid back to 0.
- Back-to-back: three windows, s_valid held high, ip_done never asserted -> s_ready = 0 after 512 beats; asserting ip_done then releases bank 0, s_ready = 1 the next cycle, and beat 512 lands in bank 0.
- Framing: s_last at beat 100, none at beat 255 -> err_frame = 1, window still presented after 256 beats; err_frame stays 1 until rst.
- Reset mid-window: rst pulse after 130 beats -> all outputs at reset values; the next 256 beats form bank 0 with the new s_ctr.
- Simultaneous set/clear: finish bank 1 on the same edge as R_REL of bank 0 -> full = 2'b10 afterwards; bank 1 presented, wr_sel = 0.
- With FME_WIN_TIMEOUT_EN and TIMEOUT_CYC = 64: ip_done held 0 -> R_REL after 64 cycles in R_WAIT; err_timeout = 1; win_cnt = 1.
